// File: rtl/tick_div_pkg.sv
// Shared constants for the tick divider block and the traffic-light timing that uses it.
// Also holds the helper that locates one channel's slice in the packed divisor bus.
package tick_div_pkg;

    localparam int CLK_HZ       = 100_000_000;
    localparam int BASE_DIV_1MS = 100000;

    // Traffic-light divisors, counted in 1 ms base ticks.
    localparam int DIV_1S    = 1000;
    localparam int DIV_BLINK = 500;

    typedef struct packed {
        logic clr;
        logic load;
        logic base_tick;
    } chan_ctrl_t;

    function automatic int slice_lo(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/tick_channel.sv
// One tick channel: divisor register, base-tick counter, one-cycle pulse and toggle.
// The control inputs arrive already prioritised, so clr wins over load and load wins over base_tick.
module tick_channel
    import tick_div_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             base_tick,
    input  logic             clr,
    input  logic             load,
    input  logic [DIV_W-1:0] div_in,
    output logic             pulse,
    output logic             toggle
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    chan_ctrl_t       ctrl;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt;
    logic             terminal;

    assign ctrl     = '{clr: clr, load: load, base_tick: base_tick};
    assign terminal = (cnt == div_q - ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= DIV_W'(DEFAULT_DIV);
            cnt    <= '0;
            pulse  <= 1'b0;
            toggle <= 1'b0;
        end else if (ctrl.clr) begin
            cnt    <= '0;
            pulse  <= 1'b0;
            toggle <= 1'b0;
        end else if (ctrl.load) begin
            // Counter restarts with the new divisor, so a shorter divisor can never be overrun.
            div_q <= div_in;
            cnt   <= '0;
            pulse <= 1'b0;
        end else if (ctrl.base_tick && (div_q != '0)) begin
            if (terminal) begin
                cnt    <= '0;
                pulse  <= 1'b1;
                toggle <= ~toggle;
            end else begin
                cnt   <= cnt + ONE;
                pulse <= 1'b0;
            end
        end else begin
            pulse <= 1'b0;
        end
    end

endmodule

// File: rtl/multi_tick_divider.sv
// Shared base prescaler feeding NUM_CH independently loadable tick channels.
// Define MULTI_TICK_DIVIDER_FAST_SIM_EN to run the prescaler at SIM_BASE_DIV for short simulations.
module multi_tick_divider
    import tick_div_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int BASE_DIV     = 100000,
    parameter int DIV_W        = 16,
    parameter int DEFAULT_DIV  = 1000,
    parameter int SIM_BASE_DIV = 10
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         en,
    input  logic                                         clr,
    input  logic                                         div_load,
    input  logic [NUM_CH*DIV_W-1:0]                      ch_div,
    output logic [NUM_CH-1:0]                            ch_pulse,
    output logic [NUM_CH-1:0]                            ch_toggle,
    output logic [((BASE_DIV > 1) ? $clog2(BASE_DIV) : 1)-1:0] base_count
);

    localparam int BC_W = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;

`ifdef MULTI_TICK_DIVIDER_FAST_SIM_EN
    localparam bit FAST_SIM = 1'b1;
`else
    localparam bit FAST_SIM = 1'b0;
`endif

    localparam int              EFF_DIV  = FAST_SIM ? SIM_BASE_DIV : BASE_DIV;
    localparam logic [BC_W-1:0] WRAP_VAL = BC_W'(EFF_DIV - 1);

    logic base_wrap;
    logic base_tick;
    logic chan_load;

    assign base_wrap = (base_count == WRAP_VAL);
    // Terminal ticks coinciding with clr or load are dropped so the new phase starts clean.
    assign base_tick = en & base_wrap & ~clr & ~div_load;
    assign chan_load = div_load & ~clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_count <= '0;
        end else if (clr || div_load) begin
            base_count <= '0;
        end else if (en) begin
            base_count <= base_wrap ? '0 : base_count + BC_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tick_channel #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .base_tick (base_tick),
            .clr       (clr),
            .load      (chan_load),
            .div_in    (ch_div[slice_lo(i, DIV_W) +: DIV_W]),
            .pulse     (ch_pulse[i]),
            .toggle    (ch_toggle[i])
        );
    end

endmodule

// File: tb/tb_multi_tick_divider.sv
// Directed bench for multi_tick_divider: base divisor 10, two channels, default divisor 4.
// Edge n means the n-th rising edge after reset release or after the load edge (edge 0).
module tb_multi_tick_divider;

    localparam int NUM_CH = 2;
    localparam int DIV_W  = 16;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    en;
    logic                    clr;
    logic                    div_load;
    logic [NUM_CH*DIV_W-1:0] ch_div;
    logic [NUM_CH-1:0]       ch_pulse;
    logic [NUM_CH-1:0]       ch_toggle;
    logic [3:0]              base_count;

    int vectors = 0;
    int errors  = 0;

    multi_tick_divider #(
        .NUM_CH       (NUM_CH),
        .BASE_DIV     (10),
        .DIV_W        (DIV_W),
        .DEFAULT_DIV  (4),
        .SIM_BASE_DIV (10)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .clr        (clr),
        .div_load   (div_load),
        .ch_div     (ch_div),
        .ch_pulse   (ch_pulse),
        .ch_toggle  (ch_toggle),
        .base_count (base_count)
    );

    always #5 clk = ~clk;

    // clr edge, then load edge (edge 0); returns at the negedge after edge 0.
    task automatic realign(input logic [15:0] d1, input logic [15:0] d0);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr      = 1'b0;
        div_load = 1'b1;
        ch_div   = {d1, d0};
        @(negedge clk);
        div_load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; div_load = 1'b0; ch_div = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if (base_count !== 4'd0) begin
            errors++; $display("FAIL reset_base: got %0d want 0", base_count);
        end
        vectors++;
        if (ch_pulse !== 2'b00) begin
            errors++; $display("FAIL reset_pulse: got %b want 00", ch_pulse);
        end
        vectors++;
        if (ch_toggle !== 2'b00) begin
            errors++; $display("FAIL reset_toggle: got %b want 00", ch_toggle);
        end
    endtask

    task automatic test_default_period();
        logic [1:0] ep, et;
        en = 1'b1; rst_n = 1'b1;
        for (int n = 1; n <= 125; n++) begin
            @(negedge clk);
            ep = (n % 40 == 0) ? 2'b11 : 2'b00;
            et = ((n / 40) % 2 == 1) ? 2'b11 : 2'b00;
            vectors++;
            if (ch_pulse !== ep || ch_toggle !== et || base_count !== 4'(n % 10)) begin
                errors++;
                $display("FAIL default_period edge %0d: pulse %b tog %b base %0d, want %b %b %0d",
                         n, ch_pulse, ch_toggle, base_count, ep, et, n % 10);
            end
        end
    endtask

    task automatic test_load_divisors();
        logic [1:0] ep, et;
        realign(16'd1, 16'd3);
        vectors++;
        if (ch_pulse !== 2'b00 || base_count !== 4'd0) begin
            errors++; $display("FAIL load_edge0: pulse %b base %0d want 00 0", ch_pulse, base_count);
        end
        for (int n = 1; n <= 65; n++) begin
            @(negedge clk);
            ep = {(n % 10 == 0), (n % 30 == 0)};
            et = {((n / 10) % 2 == 1), ((n / 30) % 2 == 1)};
            vectors++;
            if (ch_pulse !== ep || ch_toggle !== et) begin
                errors++;
                $display("FAIL load_divisors edge %0d: pulse %b tog %b, want %b %b",
                         n, ch_pulse, ch_toggle, ep, et);
            end
        end
    endtask

    task automatic test_disable();
        logic ep0;
        realign(16'd0, 16'd3);
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            ep0 = (n % 30 == 0);
            vectors++;
            if (ch_pulse[1] !== 1'b0 || ch_toggle[1] !== 1'b0 || ch_pulse[0] !== ep0) begin
                errors++;
                $display("FAIL disable edge %0d: pulse %b tog %b, want pulse %b tog1 0",
                         n, ch_pulse, ch_toggle, {1'b0, ep0});
            end
        end
    endtask

    task automatic test_en_gap();
        logic [1:0] ep, et;
        logic [3:0] eb;
        realign(16'd4, 16'd4);
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            ep = (n == 55) ? 2'b11 : 2'b00;
            et = (n >= 55) ? 2'b11 : 2'b00;
            eb = (n <= 20) ? 4'(n % 10) : (n <= 35) ? 4'd0 : 4'((n - 15) % 10);
            vectors++;
            if (ch_pulse !== ep || ch_toggle !== et || base_count !== eb) begin
                errors++;
                $display("FAIL en_gap edge %0d: pulse %b tog %b base %0d, want %b %b %0d",
                         n, ch_pulse, ch_toggle, base_count, ep, et, eb);
            end
            // Edges 21..35 see en low.
            en = !(n >= 20 && n < 35);
        end
        en = 1'b1;
    endtask

    task automatic test_load_on_terminal();
        logic [1:0] ep, et;
        realign(16'd4, 16'd4);
        repeat (39) @(negedge clk);
        div_load = 1'b1;
        ch_div   = {16'd4, 16'd2};
        @(negedge clk);
        div_load = 1'b0;
        vectors++;
        if (ch_pulse !== 2'b00 || base_count !== 4'd0 || ch_toggle !== 2'b00) begin
            errors++;
            $display("FAIL load_terminal edge 40: pulse %b tog %b base %0d, want 00 00 0",
                     ch_pulse, ch_toggle, base_count);
        end
        for (int n = 41; n <= 85; n++) begin
            @(negedge clk);
            ep = {(n == 80), (n == 60 || n == 80)};
            et = {(n >= 80), (n >= 60 && n < 80)};
            vectors++;
            if (ch_pulse !== ep || ch_toggle !== et) begin
                errors++;
                $display("FAIL load_terminal edge %0d: pulse %b tog %b, want %b %b",
                         n, ch_pulse, ch_toggle, ep, et);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [1:0] ep, et;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        vectors++;
        if (ch_pulse !== 2'b00 || ch_toggle !== 2'b00 || base_count !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: pulse %b tog %b base %0d, want 00 00 0",
                     ch_pulse, ch_toggle, base_count);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 45; n++) begin
            @(negedge clk);
            ep = (n == 40) ? 2'b11 : 2'b00;
            et = (n >= 40) ? 2'b11 : 2'b00;
            vectors++;
            if (ch_pulse !== ep || ch_toggle !== et || base_count !== 4'(n % 10)) begin
                errors++;
                $display("FAIL post_reset edge %0d: pulse %b tog %b base %0d, want %b %b %0d",
                         n, ch_pulse, ch_toggle, base_count, ep, et, n % 10);
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_period();
        test_load_divisors();
        test_disable();
        test_en_gap();
        test_load_on_terminal();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
